data_cache_controller: RTL and testbench

DATA_CACHE_CONTROLLER -- requirements
Module: data_cache_controller

---
 rtl/data_cache_controller_pkg.sv | 25 ++
 rtl/data_cache_controller_ram.sv | 27 ++
 rtl/data_cache_controller.sv | 162 ++++++++++++++++
 tb/tb_data_cache_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_controller_pkg.sv
// Shared state encoding and geometry for the direct-mapped data cache.
// Widths default here; the controller derives its own from its parameters.
package data_cache_controller_pkg;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 2;
    localparam int RAM_AW   = INDEX_W + OFFSET_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        WRITE_MEM = 2'd2
    } state_t;

    function automatic int tag_width(
        input int aw,
        input int iw,
        input int ow
    );
        return aw - iw - ow;
    endfunction

endpackage

// File: rtl/data_cache_controller_ram.sv
// Cache data array: one synchronous write port, one combinational
// read port, addressed by {index, offset}.
module cache_data_ram
    import data_cache_controller_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int AW         = RAM_AW
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [1 << AW];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Holds tags, valid bits, the refill/write FSM and the pipeline stall.
module data_cache_controller
    import data_cache_controller_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_W,
    parameter int DATA_WIDTH   = DATA_W,
    parameter int INDEX_WIDTH  = INDEX_W,
    parameter int OFFSET_WIDTH = OFFSET_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int TAG_WIDTH =
        tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);
    localparam int LINE_CNT = 1 << INDEX_WIDTH;
    localparam int RAW      = INDEX_WIDTH + OFFSET_WIDTH;

    state_t                  state;
    logic [LINE_CNT-1:0]     valid;
    logic [TAG_WIDTH-1:0]    tags [LINE_CNT];
    logic [OFFSET_WIDTH-1:0] cnt;
    logic [OFFSET_WIDTH-1:0] cnt_nxt;
    logic                    wr_done;
    logic [TAG_WIDTH-1:0]    rf_tag;
    logic [INDEX_WIDTH-1:0]  rf_idx;

    logic [TAG_WIDTH-1:0]    a_tag;
    logic [INDEX_WIDTH-1:0]  a_idx;
    logic [OFFSET_WIDTH-1:0] a_off;

    logic idle;
    logic hit;
    logic wr_req;
    logic rd_miss;
    logic beat;
    logic last_beat;

    logic                  ram_we;
    logic [RAW-1:0]        ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign {a_tag, a_idx, a_off} = cpu_addr;

    assign idle      = state == IDLE;
    assign hit       = valid[a_idx] && tags[a_idx] == a_tag;
    // A write already retired this request cycle; let the CPU move on.
    assign wr_req    = idle && cpu_wr && !wr_done;
    assign rd_miss   = idle && cpu_rd && !hit;
    assign beat      = state == REFILL && mem_ready;
    assign last_beat = beat && &cnt;
    assign cnt_nxt   = cnt + OFFSET_WIDTH'(1);

    assign stall = !RST && (!idle || wr_req || rd_miss);

    assign cpu_rdata = (idle && cpu_rd && hit) ? ram_rdata : '0;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {a_idx, a_off};
        ram_wdata = cpu_wdata;
        unique case (1'b1)
            beat: begin
                ram_we    = 1'b1;
                ram_waddr = {rf_idx, cnt};
                ram_wdata = mem_rdata;
            end
            wr_req && hit: begin
                ram_we = 1'b1;
            end
            default: ;
        endcase
    end

    cache_data_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .AW        (RAW)
    ) u_ram (
        .CLK  (CLK),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr({a_idx, a_off}),
        .rdata(ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (last_beat) begin
            tags[rf_idx] <= rf_tag;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            valid     <= '0;
            cnt       <= '0;
            wr_done   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rf_tag    <= '0;
            rf_idx    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_req) begin
                        state     <= WRITE_MEM;
                        mem_wr    <= 1'b1;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                    end else if (rd_miss) begin
                        state    <= REFILL;
                        mem_rd   <= 1'b1;
                        cnt      <= '0;
                        rf_tag   <= a_tag;
                        rf_idx   <= a_idx;
                        mem_addr <= {a_tag, a_idx,
                                     {OFFSET_WIDTH{1'b0}}};
                    end else begin
                        wr_done <= 1'b0;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        cnt      <= cnt_nxt;
                        mem_addr <= {rf_tag, rf_idx, cnt_nxt};
                        if (&cnt) begin
                            state         <= IDLE;
                            mem_rd        <= 1'b0;
                            valid[rf_idx] <= 1'b1;
                        end
                    end
                end
                WRITE_MEM: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_wr  <= 1'b0;
                        wr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// Bench for data_cache_controller: directed scenarios plus random
// loads/stores against a memory-is-truth cache model.
module tb_data_cache_controller;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_rd;
    logic        mem_wr;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    always #5 CLK = ~CLK;

    data_cache_controller dut (
        .CLK      (CLK),
        .RST      (RST),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .stall    (stall),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    logic [31:0] mem_m [1024];
    bit          v_m [16];
    logic [3:0]  t_m [16];

    int checks = 0;
    int passed = 0;
    int ready_delay = 0;
    int wait_cnt = 0;
    int stall_cycles = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;

    logic        s_stall;
    logic        s_rd;
    logic        s_wr;
    logic [9:0]  s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic [9:0]  rd_q [$];
    logic [9:0]  wr_q [$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h",
                    tag, obs, exp);
    endtask

    task automatic clr_stats();
        stall_cycles = 0;
        rd_cycles = 0;
        wr_cycles = 0;
        wait_cnt = 0;
        rd_q.delete();
        wr_q.delete();
    endtask

    // One clock: sample at negedge, answer as memory, commit at posedge.
    task automatic tick();
        @(negedge CLK);
        s_stall = stall;
        s_rd    = mem_rd;
        s_wr    = mem_wr;
        s_addr  = mem_addr;
        s_wdata = mem_wdata;
        s_rdata = cpu_rdata;
        if (mem_rd || mem_wr) begin
            mem_ready = (wait_cnt == ready_delay);
            mem_rdata = mem_m[mem_addr];
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
        if (s_stall) stall_cycles++;
        if (s_rd) rd_cycles++;
        if (s_wr) wr_cycles++;
        @(posedge CLK);
        if (s_rd && mem_ready) rd_q.push_back(s_addr);
        if (s_wr && mem_ready) begin
            wr_q.push_back(s_addr);
            mem_m[s_addr] = s_wdata;
        end
        if (s_rd || s_wr)
            wait_cnt = mem_ready ? 0 : wait_cnt + 1;
        else
            wait_cnt = 0;
        #1;
    endtask

    task automatic run_op(input bit rd, input bit wr,
                          input logic [9:0] a,
                          input logic [31:0] d,
                          input int dly);
        logic [3:0] idx;
        logic [3:0] tg;
        bit         hit;
        int         exp_stall;
        int         n;
        logic [9:0] exp_q [$];
        string      t;
        idx = a[5:2];
        tg  = a[9:6];
        hit = v_m[idx] && t_m[idx] == tg;
        exp_stall = 0;
        if (wr) exp_stall += 2 + dly;
        if (rd && !hit) begin
            exp_stall += 1 + 4 * (dly + 1);
            for (int k = 0; k < 4; k++)
                exp_q.push_back({a[9:2], 2'(k)});
        end
        t = $sformatf("op rd%0d wr%0d @%0h", rd, wr, a);
        clr_stats();
        ready_delay = dly;
        cpu_rd = rd;
        cpu_wr = wr;
        cpu_addr = a;
        cpu_wdata = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (s_stall && n < 300);
        chk({t, " done"}, 32'(s_stall), 0);
        chk({t, " stall"}, stall_cycles, exp_stall);
        chk({t, " rd beats"}, rd_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < rd_q.size(); k++)
            chk({t, " rd addr"}, 32'(rd_q[k]), 32'(exp_q[k]));
        chk({t, " wr beats"}, wr_q.size(), 32'(wr));
        chk({t, " wr hold"}, wr_cycles, wr ? dly + 1 : 0);
        if (wr_q.size() > 0)
            chk({t, " wr addr"}, 32'(wr_q[0]), 32'(a));
        if (wr)
            chk({t, " wr data"}, mem_m[a], d);
        chk({t, " strobes"}, {30'd0, s_rd, s_wr}, 0);
        if (rd)
            chk({t, " rdata"}, s_rdata, mem_m[a]);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        if (rd && !hit) begin
            v_m[idx] = 1'b1;
            t_m[idx] = tg;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'(i);
        for (int i = 0; i < 16; i++) begin
            v_m[i] = 1'b0;
            t_m[i] = '0;
        end

        #2 RST = 1'b1;
        #1;
        chk("rst stall", 32'(stall), 0);
        chk("rst mem_rd", 32'(mem_rd), 0);
        chk("rst mem_wr", 32'(mem_wr), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst cpu_rdata", cpu_rdata, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK);
        #1;

        run_op(0, 0, 10'h012, 32'h0, 0);
        run_op(1, 0, 10'h012, 32'h0, 0);
        run_op(1, 0, 10'h013, 32'h0, 0);
        run_op(0, 1, 10'h011, 32'hDEADBEEF, 2);
        run_op(1, 0, 10'h011, 32'h0, 0);
        run_op(0, 1, 10'h3FF, 32'hCAFE0001, 1);
        run_op(1, 0, 10'h3FF, 32'h0, 0);

        // Abort a refill after two beats with a reset pulse.
        clr_stats();
        ready_delay = 0;
        cpu_rd = 1'b1;
        cpu_addr = 10'h112;
        repeat (3) tick();
        chk("abort beats", rd_q.size(), 2);
        RST = 1'b1;
        cpu_rd = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("abort stall", 32'(stall), 0);
        chk("abort mem_rd", 32'(mem_rd), 0);
        chk("abort mem_addr", 32'(mem_addr), 0);
        for (int i = 0; i < 16; i++) v_m[i] = 1'b0;
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK);
        #1;
        run_op(1, 0, 10'h012, 32'h0, 0);
        run_op(1, 0, 10'h112, 32'h0, 0);
        run_op(1, 0, 10'h012, 32'h0, 1);

        run_op(1, 1, 10'h020, 32'h12345678, 1);
        run_op(1, 1, 10'h021, 32'h0BADF00D, 0);

        for (int i = 0; i < 80; i++) begin
            logic [9:0] ra;
            ra = {4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3))};
            run_op(1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   ra, $urandom,
                   $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
